vga_reg_commit_ctrl: RTL
========================

Name: vga_reg_commit_ctrl

Overview:
- Sits between the register writers and the sprite/score display block's register port (chipselect/write/address/writedata).
- Two writers feed it: the HPS Avalon slave (CPU) and the hardware game-logic engine.
- It arbitrates writes between them, buffers them in a FIFO, and replays them to the display only during vertical blanking, so sprite positions and score change atomically per frame with no tearing.
- It also keeps a frame counter.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, 2..64).
- NUM_REGS, 13, valid register addresses 0..NUM_REGS-1; all others are rejected.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- cpu_chipselect  in  1  CPU write select
- cpu_write  in  1  CPU write strobe
- cpu_address  in  9  CPU register address
- cpu_writedata  in  32  CPU write data
- cpu_waitrequest  out  1  CPU must hold request while high
- hw_req  in  1  hardware writer request (held until granted)
- hw_address  in  9  hardware register address
- hw_writedata  in  32  hardware write data
- hw_grant  out  1  one-cycle acceptance pulse for hw request
- vblank  in  1  high while vcount >= 480 (from display timing)
- out_chipselect  out  1  to display block
- out_write  out  1  to display block
- out_address  out  9  to display block
- out_writedata  out  32  to display block
- frame_count  out  16  completed frames
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- err_sticky  out  2  bit0 bad address seen, bit1 reserved (0); cleared only by reset

Behaviour:
- Reset values:
  - all outputs 0; FIFO empty; FSM=IDLE; rr_last=HW (so CPU wins first tie).
  - vblank_q captures vblank as 0, so a vblank already high at reset release triggers a commit.
- Request definitions: cpu_req = cpu_chipselect & cpu_write; hw request = hw_req.
- Enqueue arbitration (combinational grant, registered FIFO write):
  - Only one request present and FIFO not full: grant it.
  - Both present: round-robin; the winner is the one not equal to rr_last; rr_last updates on every grant.
  - FIFO full: no grant.
  - cpu_waitrequest = cpu_req & ~cpu_grant.
  - hw_grant = hw_grant_comb; it is high in the accepting cycle only.
  - Grant and FIFO push occur on the same clock edge.
- Address check: a granted request with address >= NUM_REGS is acknowledged but not pushed, and sets err_sticky[0].
- Edge detect: vblank_q registered each cycle; vb_rise = vblank & ~vblank_q.
- FSM:
  - IDLE: on vb_rise, frame_count += 1 (16-bit wrap 0xFFFF->0), snap = fifo_level, go to DRAIN if snap != 0, else WAIT_LOW.
  - DRAIN: each cycle while remaining != 0 and vblank=1, pop head.
    - Next cycle present out_chipselect=out_write=1 with the popped address/data; remaining -= 1.
    - remaining reaches 0: go to WAIT_LOW.
    - vblank falls first: abort and go to WAIT_LOW. Un-popped entries stay queued for the next frame, order preserved.
  - WAIT_LOW: stay until vblank=0, then IDLE. A vb_rise is impossible here since vblank is high.
- Snapshot rule: only entries present at vb_rise commit that frame. Entries enqueued during DRAIN wait for the next vblank, even though push and pop happen in the same cycle.
- Latency: vb_rise detected at edge t (vblank_q=0, vblank=1 sampled) -> first out_write high in cycle t+1 -> one write per cycle, back-to-back.
- out_* are registered; out_chipselect/out_write deassert the cycle after the last pop.
- Simultaneous push and pop: occupancy unchanged. Full + pop in the same cycle: the push is still refused, because the full check uses current occupancy.
- FIFO order: strict FIFO across both sources.
- Reset mid-operation: FIFO flushed, drain aborted immediately, out_write=0 on the next cycle.

Test Plan:
- Single CPU write: addr 0, data 0x64 during active video -> no out_write until vblank rises; then out_write for exactly 1 cycle with addr 0, data 0x64, one cycle after vb_rise; frame_count 0->1.
- Contention: cpu_req and hw_req held together for 4 cycles with FIFO empty -> grants alternate CPU, HW, CPU, HW; at next vblank, 4 out_writes in that order.
- Full FIFO: 9 CPU writes while vblank=0 with DEPTH=8 -> 8 accepted; cpu_waitrequest stays 1 on the 9th until vblank drain pops; fifo_level=8 max.
- Bad address: CPU writes addr 13 -> accepted (waitrequest 0), no FIFO entry, err_sticky[0]=1; drain produces 0 writes.
- Snapshot and abort:
  - 3 entries queued; a hw write arrives during DRAIN -> exactly 3 writes this vblank, the 4th next vblank.
  - Separately: force vblank low after 2 pops -> the remaining entry commits next frame.
- Reset mid-DRAIN: assert reset after the first out_write -> out_write=0 next cycle; fifo_level=0, frame_count=0; no writes at the following vblank.

Source files
------------

// File: rtl/vga_reg_commit_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_reg_commit_ctrl_if
// Bundles the three register-write buses around the commit controller:
//   cpu_*  : Avalon-style CPU write port (chipselect/write/address/writedata,
//            waitrequest back to the CPU)
//   hw_*   : game-logic engine write port (req held until hw_grant pulses)
//   out_*  : replayed writes toward the sprite/score display block
// Modports:
//   master : the writer/display side (drives cpu_* and hw_* requests)
//   slave  : the commit controller itself
// ---------------------------------------------------------------------------
interface vga_reg_commit_ctrl_if;
   logic        cpu_chipselect;
   logic        cpu_write;
   logic [8:0]  cpu_address;
   logic [31:0] cpu_writedata;
   logic        cpu_waitrequest;

   logic        hw_req;
   logic [8:0]  hw_address;
   logic [31:0] hw_writedata;
   logic        hw_grant;

   logic        out_chipselect;
   logic        out_write;
   logic [8:0]  out_address;
   logic [31:0] out_writedata;

   modport master (
      output cpu_chipselect, cpu_write, cpu_address, cpu_writedata,
      output hw_req, hw_address, hw_writedata,
      input  cpu_waitrequest, hw_grant,
      input  out_chipselect, out_write, out_address, out_writedata
   );

   modport slave (
      input  cpu_chipselect, cpu_write, cpu_address, cpu_writedata,
      input  hw_req, hw_address, hw_writedata,
      output cpu_waitrequest, hw_grant,
      output out_chipselect, out_write, out_address, out_writedata
   );
endinterface

// File: rtl/vga_reg_commit_ctrl.sv
// ---------------------------------------------------------------------------
// vga_reg_commit_ctrl
// Arbitrates register writes from the CPU and the hardware game engine,
// queues them in a FIFO and replays them to the display block only during
// vertical blanking, so a frame's sprite/score updates land atomically.
// Only entries already queued when vblank rises are committed in that
// blanking interval; later entries wait for the next frame.
// Ports:
//   clk, reset   : 50 MHz clock, asynchronous active-high reset
//   bus          : cpu_* / hw_* request buses and out_* display bus
//   vblank       : high while the display is in vertical blanking
//   frame_count  : number of vblank rising edges seen (wraps at 16 bits)
//   fifo_level   : current FIFO occupancy
//   err_sticky   : bit0 = out-of-range address seen, bit1 reserved (0)
// ---------------------------------------------------------------------------
module vga_reg_commit_ctrl #(
   parameter int DEPTH    = 8,
   parameter int NUM_REGS = 13
) (
   input  logic                     clk,
   input  logic                     reset,
   vga_reg_commit_ctrl_if.slave     bus,
   input  logic                     vblank,
   output logic [15:0]              frame_count,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [1:0]               err_sticky
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 41;                       // {address[8:0], data[31:0]}
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [8:0]    NUM_REGS_C = 9'(NUM_REGS);
   localparam logic          RR_CPU     = 1'b0;
   localparam logic          RR_HW      = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_WAIT_LOW = 2'd2
   } state_t;

   // FIFO storage and bookkeeping
   logic [EW-1:0]  mem_r [DEPTH];
   logic [PW-1:0]  wr_ptr_r;
   logic [PW-1:0]  rd_ptr_r;
   logic [CW-1:0]  count_r;

   // Arbitration
   logic           rr_last_r;
   logic           cpu_req_s;
   logic           full_s;
   logic           cpu_grant_s;
   logic           hw_grant_s;
   logic           any_grant_s;
   logic [8:0]     sel_addr_s;
   logic [31:0]    sel_data_s;
   logic           bad_addr_s;
   logic           push_s;
   logic           err_r;

   // Commit sequencing
   logic           vblank_q_r;
   logic           vb_rise_s;
   state_t         state_r;
   state_t         state_s;
   logic [CW-1:0]  remaining_r;
   logic [CW-1:0]  remaining_s;
   logic [15:0]    frame_count_r;
   logic [15:0]    frame_count_s;
   logic           pop_s;
   logic [EW-1:0]  head_s;

   // Registered display bus
   logic           out_write_r;
   logic [8:0]     out_address_r;
   logic [31:0]    out_writedata_r;

   assign cpu_req_s   = bus.cpu_chipselect & bus.cpu_write;
   assign full_s      = (count_r == DEPTH_C);
   assign vb_rise_s   = vblank & ~vblank_q_r;
   assign head_s      = mem_r[rd_ptr_r];
   assign any_grant_s = cpu_grant_s | hw_grant_s;

   // Grant selection: round-robin on a tie, nothing while the FIFO is full.
   always_comb begin
      cpu_grant_s = 1'b0;
      hw_grant_s  = 1'b0;
      if (!full_s) begin
         if (cpu_req_s && bus.hw_req) begin
            if (rr_last_r == RR_HW) begin
               cpu_grant_s = 1'b1;
            end else begin
               hw_grant_s = 1'b1;
            end
         end else if (cpu_req_s) begin
            cpu_grant_s = 1'b1;
         end else if (bus.hw_req) begin
            hw_grant_s = 1'b1;
         end else begin
            cpu_grant_s = 1'b0;
            hw_grant_s  = 1'b0;
         end
      end else begin
         cpu_grant_s = 1'b0;
         hw_grant_s  = 1'b0;
      end
   end

   // Winner's address/data, and whether it may enter the FIFO.
   always_comb begin
      sel_addr_s = 9'd0;
      sel_data_s = 32'd0;
      if (cpu_grant_s) begin
         sel_addr_s = bus.cpu_address;
         sel_data_s = bus.cpu_writedata;
      end else if (hw_grant_s) begin
         sel_addr_s = bus.hw_address;
         sel_data_s = bus.hw_writedata;
      end else begin
         sel_addr_s = 9'd0;
         sel_data_s = 32'd0;
      end
      // Out-of-range writes are acknowledged but silently dropped.
      bad_addr_s = any_grant_s & (sel_addr_s >= NUM_REGS_C);
      push_s     = any_grant_s & ~bad_addr_s;
   end

   assign bus.cpu_waitrequest = cpu_req_s & ~cpu_grant_s;
   assign bus.hw_grant        = hw_grant_s;

   // FIFO data array; pointers alone define validity, so no reset needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {sel_addr_s, sel_data_s};
      end
   end

   // FIFO pointers/occupancy; a simultaneous push and pop leaves count as is.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Round-robin history and sticky address error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_last_r <= RR_HW;
         err_r     <= 1'b0;
      end else begin
         if (any_grant_s) begin
            rr_last_r <= hw_grant_s ? RR_HW : RR_CPU;
         end
         if (bad_addr_s) begin
            err_r <= 1'b1;
         end
      end
   end

   // Commit FSM next-state: snapshot occupancy at vblank rise, then drain it.
   always_comb begin
      state_s       = state_r;
      remaining_s   = remaining_r;
      frame_count_s = frame_count_r;
      pop_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (vb_rise_s) begin
               frame_count_s = frame_count_r + 16'd1;
               remaining_s   = count_r;
               if (count_r != '0) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_WAIT_LOW;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (vblank && (remaining_r != '0)) begin
               pop_s       = 1'b1;
               remaining_s = remaining_r - CW'(1);
               if (remaining_r == CW'(1)) begin
                  state_s = ST_WAIT_LOW;
               end else begin
                  state_s = ST_DRAIN;
               end
            end else begin
               // vblank ended early: leftover entries keep their order.
               state_s = ST_WAIT_LOW;
            end
         end
         ST_WAIT_LOW: begin
            if (!vblank) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WAIT_LOW;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Commit FSM state, frame counter and vblank edge history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         remaining_r   <= '0;
         frame_count_r <= 16'd0;
         vblank_q_r    <= 1'b0;
      end else begin
         state_r       <= state_s;
         remaining_r   <= remaining_s;
         frame_count_r <= frame_count_s;
         vblank_q_r    <= vblank;
      end
   end

   // Display bus: one registered write per popped entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_write_r     <= 1'b0;
         out_address_r   <= 9'd0;
         out_writedata_r <= 32'd0;
      end else begin
         out_write_r <= pop_s;
         if (pop_s) begin
            out_address_r   <= head_s[EW-1:32];
            out_writedata_r <= head_s[31:0];
         end else begin
            out_address_r   <= 9'd0;
            out_writedata_r <= 32'd0;
         end
      end
   end

   assign bus.out_chipselect = out_write_r;
   assign bus.out_write      = out_write_r;
   assign bus.out_address    = out_address_r;
   assign bus.out_writedata  = out_writedata_r;
   assign frame_count        = frame_count_r;
   assign fifo_level         = count_r;
   assign err_sticky         = {1'b0, err_r};

endmodule
